// File: rtl/seq_shift_add_multiplier_param.sv
// Parametrised sequential shift-and-add multiplier: one multiplier bit per clock, signed/unsigned per operation.
// Optional build macro MULT_ZERO_SKIP_EN: a zero-magnitude operand bypasses the remaining add/shift iterations.
module seq_shift_add_multiplier_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] mreg_q, mreg_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             neg_q, neg_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    p_raw;

  // Two's complement magnitude; -2^(W-1) maps to 2^(W-1), which is still exact as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    mreg_d    = mreg_q;
    qreg_d    = qreg_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;
    sum       = {1'b0, a_q} + (qreg_q[0] ? {1'b0, mreg_q} : (WIDTH + 1)'(0));
    p_raw     = {a_q, qreg_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mreg_d  = M;
          qreg_d  = Q;
          sgn_d   = is_signed;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        mreg_d  = sgn_q ? mag(mreg_q) : mreg_q;
        qreg_d  = sgn_q ? mag(qreg_q) : qreg_q;
        // A zero operand forces a non-negative result so no sign correction is applied.
        neg_d   = sgn_q & (mreg_q[WIDTH-1] ^ qreg_q[WIDTH-1])
                  & (mreg_q != '0) & (qreg_q != '0);
        a_d     = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        {a_d, qreg_d} = PW'({sum, qreg_q} >> 1);
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
`ifdef MULT_ZERO_SKIP_EN
        if ((cnt_q == '0) && ((mreg_q == '0) || (qreg_q == '0))) begin
          a_d     = '0;
          qreg_d  = '0;
          neg_d   = 1'b0;
          state_d = S_FIX;
        end
`endif
      end
      S_FIX: begin
        product_d = neg_q ? (~p_raw + PW'(1)) : p_raw;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      mreg_q    <= '0;
      qreg_q    <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      mreg_q    <= mreg_d;
      qreg_q    <= qreg_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      neg_q     <= neg_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier_param.sv
// Bench for seq_shift_add_multiplier_param: WIDTH=8 and WIDTH=32 instances checked against a plain-arithmetic model.
module tb_seq_shift_add_multiplier_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st8 = 1'b0, st32 = 1'b0;
  logic        sg_in = 1'b0;
  logic [31:0] m_in = '0, q_in = '0;
  logic        ready8, busy8, done8;
  logic        ready32, busy32, done32;
  logic [15:0] prod8;
  logic [63:0] prod32;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier_param #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(st8), .is_signed(sg_in),
    .M(m_in[7:0]), .Q(q_in[7:0]),
    .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
  );

  seq_shift_add_multiplier_param #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(st32), .is_signed(sg_in),
    .M(m_in), .Q(q_in),
    .ready(ready32), .busy(busy32), .done(done32), .product(prod32)
  );

  // Reference: sign-extend (if signed) to 64 bits, multiply, keep the low 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q,
                                          input logic s, input int w);
    logic [63:0] mk, mm, qq, p;
    mk = (64'd1 << w) - 64'd1;
    mm = {32'd0, m} & mk;
    qq = {32'd0, q} & mk;
    if (s && mm[w-1]) mm = mm | ~mk;
    if (s && qq[w-1]) qq = qq | ~mk;
    p = mm * qq;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  function automatic int exp_lat(input logic [31:0] m, input logic [31:0] q, input int w);
    logic [63:0] mk;
    mk = (64'd1 << w) - 64'd1;
`ifdef MULT_ZERO_SKIP_EN
    if ((({32'd0, m} & mk) == 64'd0) || (({32'd0, q} & mk) == 64'd0)) return 3;
`endif
    return w + 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One operation on the selected instance; optionally pulses a conflicting start mid-RUN.
  task automatic op(input bit w8, input logic [31:0] m, input logic [31:0] q,
                    input logic s, input bit intf);
    int          w, n, lat;
    logic [63:0] expv;
    w    = w8 ? 8 : 32;
    expv = ref_mul(m, q, s, w);
    lat  = exp_lat(m, q, w);
    @(negedge clk);
    chk("ready_before", w8 ? ready8 : ready32, 1);
    m_in = m; q_in = q; sg_in = s;
    if (w8) st8 = 1'b1; else st32 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0; st32 = 1'b0;
    n = 0;
    while (!(w8 ? done8 : done32) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (intf && n == 3) begin
        chk("intf_ready_low", w8 ? ready8 : ready32, 0);
        chk("intf_busy_high", w8 ? busy8 : busy32, 1);
        m_in = ~m; q_in = q ^ 32'h5A5A_5A5A; sg_in = ~s;
        if (w8) st8 = 1'b1; else st32 = 1'b1;
      end
      if (intf && n == 4) begin st8 = 1'b0; st32 = 1'b0; end
    end
    chk("latency", 64'(n), 64'(lat));
    chk("product", w8 ? {48'd0, prod8} : prod32, expv);
    @(posedge clk); #1;
    chk("done_pulse_end", w8 ? done8 : done32, 0);
    chk("ready_after", w8 ? ready8 : ready32, 1);
    chk("product_held", w8 ? {48'd0, prod8} : prod32, expv);
  endtask

  initial begin
    int          n, seen;
    logic [31:0] rm, rq;
    logic        rs;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready8", ready8, 1);  chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);    chk("rst_prod8", prod8, 0);
    chk("rst_ready32", ready32, 1); chk("rst_prod32", prod32, 0);
    @(negedge clk); reset = 1'b0;

    // Directed cases
    op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    op(1, 32'h80, 32'h80, 1'b1, 0);
    op(1, 32'h80, 32'h01, 1'b1, 0);
    op(1, 32'h05, 32'hFD, 1'b1, 0);
    op(1, 32'h80, 32'h80, 1'b0, 0);
    op(1, 32'hFD, 32'h05, 1'b0, 0);
    op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 0);

    // Zero operands, both modes
    op(1, 32'h00, 32'hC3, 1'b0, 0);
    op(1, 32'hC3, 32'h00, 1'b1, 0);
    op(0, 32'h0, 32'h1234_5678, 1'b1, 0);
    op(0, 32'hF000_0001, 32'h0, 1'b0, 0);

    // Start during RUN is ignored
    op(1, 32'h7B, 32'h9C, 1'b1, 1);
    op(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1);

    // Reset mid-RUN: immediate reset values, no done afterwards
    @(negedge clk);
    m_in = 32'h37; q_in = 32'h5B; sg_in = 1'b0; st8 = 1'b1;
    @(posedge clk); #1; st8 = 1'b0;
    repeat (5) @(posedge clk);
    #3; reset = 1'b1; #1;
    chk("midrst_ready", ready8, 1); chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);   chk("midrst_prod", prod8, 0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (14) begin @(posedge clk); #1; if (done8) seen = 1; end
    chk("midrst_no_done", 64'(seen), 0);
    chk("midrst_prod_zero", prod8, 0);
    op(1, 32'h37, 32'h5B, 1'b0, 0);

    // Back-to-back with start held high; operands re-sampled at each accept
    @(negedge clk);
    m_in = 32'h0E; q_in = 32'hF9; sg_in = 1'b1; st8 = 1'b1;
    @(posedge clk); #1;
    m_in = 32'hA1; q_in = 32'h33; sg_in = 1'b0;
    n = 0;
    while (!done8 && n < 100) begin @(posedge clk); #1; n++; end
    chk("b2b_lat1", 64'(n), 10);
    chk("b2b_prod1", prod8, ref_mul(32'h0E, 32'hF9, 1'b1, 8));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done8 && n < 100);
    st8 = 1'b0;
    chk("b2b_lat2", 64'(n), 11);
    chk("b2b_prod2", prod8, ref_mul(32'hA1, 32'h33, 1'b0, 8));
    repeat (3) @(posedge clk);

    // Randomised operations
    for (int i = 0; i < 24; i++) begin
      rm = $urandom; rq = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 8 == 7) rm = '0;
      op(1, rm, rq, rs, 0);
    end
    for (int i = 0; i < 6; i++) begin
      rm = $urandom; rq = $urandom; rs = 1'($urandom_range(0, 1));
      op(0, rm, rq, rs, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
